// File: rtl/hdmi_lock_ctrl_pkg.sv
// Shared definitions for the HDMI lock sequencer: state codes, sync-word
// field positions and channel count.
package hdmi_pkg;

  localparam int NCHAN          = 3;
  localparam int SYNC_W         = 5;
  localparam int SYNC_VALID_BIT = 4;
  localparam int SYNC_LOC_MSB   = 3;
  localparam int LOC_W          = SYNC_LOC_MSB + 1;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_SEARCH  = 3'd1,
    S_VERIFY  = 3'd2,
    S_LOCKED  = 3'd3,
    S_BACKOFF = 3'd4
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_lock_ctrl_if.sv
// Bundle between the lock sequencer, the three TMDS aligners and the decoder.
// master = sequencer side, slave = aligner/decoder side.
interface hdmi_lock_ctrl_if;
  import hdmi_pkg::*;

  logic [NCHAN*SYNC_W-1:0] i_sync;
  logic [NCHAN-1:0]        o_chan_reset;
  logic                    o_locked;
  logic [2:0]              o_state;
  logic [NCHAN*LOC_W-1:0]  o_locs;
  logic [7:0]              o_retries;
  logic [15:0]             o_loss_count;

  modport master (
    input  i_sync,
    output o_chan_reset, o_locked, o_state, o_locs, o_retries, o_loss_count
  );

  modport slave (
    output i_sync,
    input  o_chan_reset, o_locked, o_state, o_locs, o_retries, o_loss_count
  );

endinterface

// File: rtl/hdmi_lock_ctrl_satcounter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module satcounter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      o_count <= '0;
    else if (i_inc && (o_count != {WIDTH{1'b1}}))
      o_count <= o_count + WIDTH'(1);
  end

endmodule

// File: rtl/hdmi_lock_ctrl.sv
// HDMI pixel-sync lock sequencer: resets the three aligners, searches, verifies and holds lock.
// Define HDMI_LOCK_STATS_EN to build the lock-loss event counter (otherwise o_loss_count is 0).
//
// state     | meaning
// S_RESET   | aligner resets held high for RESET_CYCLES
// S_SEARCH  | waiting for all three channels to report sync
// S_VERIFY  | locations must stay valid and unchanged for the verify window
// S_LOCKED  | link locked; tolerate short invalid bursts
// S_BACKOFF | failed attempt, wait before retrying
module hdmi_lock_ctrl
  import hdmi_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int LGTIMEOUT    = 20,
  parameter int LGVERIFY     = 16,
  parameter int LGBACKOFF    = 12,
  parameter int LOSS_GRACE   = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  hdmi_lock_ctrl_if.master bus
);

  localparam int TW = max_of(max_of(LGTIMEOUT, LGVERIFY), max_of(LGBACKOFF, 8));

  localparam logic [TW-1:0] RESET_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'((64'd1 << LGTIMEOUT) - 64'd1);
  localparam logic [TW-1:0] VERIFY_MAX  = TW'((64'd1 << LGVERIFY) - 64'd1);
  localparam logic [TW-1:0] BACKOFF_MAX = TW'((64'd1 << LGBACKOFF) - 64'd1);
  localparam logic [7:0]    GRACE_MAX   = 8'(LOSS_GRACE);

  state_t                 state_q;
  logic [TW-1:0]          timer_q;
  logic [NCHAN-1:0]       chan_reset_q;
  logic                   locked_q;
  logic [NCHAN*LOC_W-1:0] locs_q;
  logic [7:0]             grace_q;

  logic [NCHAN-1:0]       valid;
  logic [NCHAN*LOC_W-1:0] locs_in;
  logic [NCHAN-1:0]       loc_diff;
  logic                   all_valid;
  logic                   verify_fail;
  logic                   lock_mismatch;
  logic                   retry_inc;
  logic                   loss_event;

  always_comb begin
    valid    = '0;
    locs_in  = '0;
    loc_diff = '0;
    for (int c = 0; c < NCHAN; c++) begin
      valid[c]                    = bus.i_sync[c*SYNC_W + SYNC_VALID_BIT];
      locs_in[c*LOC_W +: LOC_W]   = bus.i_sync[c*SYNC_W +: LOC_W];
      loc_diff[c]                 = (bus.i_sync[c*SYNC_W +: LOC_W] != locs_q[c*LOC_W +: LOC_W]);
    end
  end

  assign all_valid     = &valid;
  assign verify_fail   = !all_valid || (|loc_diff);
  // In lock, a moved location only counts when that channel claims sync.
  assign lock_mismatch = |(valid & loc_diff);

  assign retry_inc  = ((state_q == S_SEARCH) && !all_valid && (timer_q == TIMEOUT_MAX))
                   || ((state_q == S_VERIFY) && verify_fail);
  assign loss_event = (state_q == S_LOCKED) && (lock_mismatch || (grace_q == GRACE_MAX));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_RESET;
      timer_q      <= '0;
      chan_reset_q <= {NCHAN{1'b1}};
      locked_q     <= 1'b0;
      locs_q       <= '0;
      grace_q      <= '0;
    end else begin
      case (state_q)
        S_RESET: begin
          chan_reset_q <= {NCHAN{1'b1}};
          locked_q     <= 1'b0;
          if (timer_q == RESET_LAST) begin
            state_q      <= S_SEARCH;
            timer_q      <= '0;
            chan_reset_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_SEARCH: begin
          if (all_valid) begin
            locs_q  <= locs_in;
            timer_q <= '0;
            state_q <= S_VERIFY;
          end else if (timer_q == TIMEOUT_MAX) begin
            timer_q <= '0;
            state_q <= S_BACKOFF;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_VERIFY: begin
          if (verify_fail) begin
            timer_q <= '0;
            state_q <= S_BACKOFF;
          end else if (timer_q == VERIFY_MAX) begin
            timer_q  <= '0;
            grace_q  <= '0;
            locked_q <= 1'b1;
            state_q  <= S_LOCKED;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_LOCKED: begin
          if (loss_event) begin
            locked_q     <= 1'b0;
            chan_reset_q <= {NCHAN{1'b1}};
            timer_q      <= '0;
            grace_q      <= '0;
            state_q      <= S_RESET;
          end else if (all_valid) begin
            grace_q <= '0;
          end else begin
            grace_q <= grace_q + 8'd1;
          end
        end

        S_BACKOFF: begin
          if (timer_q == BACKOFF_MAX) begin
            timer_q      <= '0;
            chan_reset_q <= {NCHAN{1'b1}};
            state_q      <= S_RESET;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        default: begin
          state_q      <= S_RESET;
          timer_q      <= '0;
          chan_reset_q <= {NCHAN{1'b1}};
          locked_q     <= 1'b0;
          grace_q      <= '0;
        end
      endcase
    end
  end

  satcounter #(.WIDTH(8)) u_retries (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_inc   (retry_inc),
    .o_count (bus.o_retries)
  );

`ifdef HDMI_LOCK_STATS_EN
  satcounter #(.WIDTH(16)) u_loss_count (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_inc   (loss_event),
    .o_count (bus.o_loss_count)
  );
`else
  assign bus.o_loss_count = 16'h0;
`endif

  assign bus.o_chan_reset = chan_reset_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_state      = state_q;
  assign bus.o_locs       = locs_q;

endmodule
